// File: rtl/weight_load_control_unit.sv
// weight_load_control_unit: streams weight tiles from the weight buffer into the
// shadow bank of a double-buffered MAC array and tracks bank/tile availability.
module weight_load_control_unit #(
  parameter int MUL_SIZE    = 32,
  parameter int ADDR_W      = 14,
  parameter int SWAP_CYCLES = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instruction_i,
  input  logic [8:0]        W_tiles_i,
  input  logic [ADDR_W-1:0] weight_base_addr_i,
  input  logic              next_weight_tile_i,
  output logic              weight_rd_en_o,
  output logic [ADDR_W-1:0] weight_rd_addr_o,
  output logic              weight_shift_o,
  output logic              weight_load_bank_o,
  output logic              compute_weights_rdy_o,
  output logic              done_o
);
  localparam int RW = $clog2(MUL_SIZE);
  localparam int DW = $clog2(SWAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SLOT, FINISH} state_t;

  state_t            r_state, w_next;
  logic [8:0]        r_tiles, r_issued;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_full, w_full_next;
  logic [1:0]        r_bank_free, w_bank_free;
  logic [DW-1:0]     r_drain [2];
  logic              r_last, r_ret_bank;
  logic              w_start, w_last_row, w_retire, w_done, w_slot, w_slot_next;

  assign w_start          = (r_state == IDLE) && instruction_i;
  assign weight_rd_en_o   = (r_state == LOAD);
  assign weight_rd_addr_o = r_addr;
  assign w_last_row       = weight_rd_en_o && (r_row == RW'(MUL_SIZE - 1));
  assign w_retire         = next_weight_tile_i && (r_full != 2'd0);
  assign w_full_next      = r_full + {1'b0, r_last} - {1'b0, w_retire};
  assign w_done           = (r_state == FINISH) && (r_full == 2'd0) && !weight_shift_o;
  // A draining bank counts as free on its last drain cycle so the next tile starts without a bubble
  assign w_bank_free[0]   = r_bank_free[0] | (r_drain[0] == DW'(1));
  assign w_bank_free[1]   = r_bank_free[1] | (r_drain[1] == DW'(1));
  assign w_slot           = (r_full < 2'd2) && w_bank_free[weight_load_bank_o];
  assign w_slot_next      = (r_full < 2'd2) && w_bank_free[~weight_load_bank_o];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (instruction_i) w_next = (W_tiles_i == 9'd0) ? FINISH : LOAD;
      LOAD:      if (w_last_row) w_next = (r_issued + 9'd1 == r_tiles) ? FINISH : (w_slot_next ? LOAD : WAIT_SLOT);
      WAIT_SLOT: if (w_slot) w_next = LOAD;
      FINISH:    if (w_done) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tiles               <= '0;
      r_issued              <= '0;
      r_row                 <= '0;
      r_addr                <= '0;
      r_full                <= '0;
      r_bank_free           <= 2'b11;
      r_drain[0]            <= '0;
      r_drain[1]            <= '0;
      r_last                <= 1'b0;
      r_ret_bank            <= 1'b1;
      weight_shift_o        <= 1'b0;
      weight_load_bank_o    <= 1'b1;
      compute_weights_rdy_o <= 1'b0;
      done_o                <= 1'b0;
    end else begin
      weight_shift_o        <= weight_rd_en_o;
      r_last                <= w_last_row;
      r_full                <= w_full_next;
      compute_weights_rdy_o <= (w_full_next != 2'd0);
      done_o                <= w_done;
      if (w_start) begin
        r_tiles            <= W_tiles_i;
        r_addr             <= weight_base_addr_i;
        r_issued           <= '0;
        r_row              <= '0;
        weight_load_bank_o <= 1'b1;
        r_ret_bank         <= 1'b1;
        r_bank_free        <= 2'b11;
        r_drain[0]         <= '0;
        r_drain[1]         <= '0;
      end else begin
        if (weight_rd_en_o) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_row  <= r_row + RW'(1);
        end
        for (int b = 0; b < 2; b++) begin
          if (r_drain[b] != '0) r_drain[b] <= r_drain[b] - DW'(1);
          if (r_drain[b] == DW'(1)) r_bank_free[b] <= 1'b1;
        end
        if (w_last_row) begin
          r_issued                        <= r_issued + 9'd1;
          weight_load_bank_o              <= ~weight_load_bank_o;
          r_bank_free[weight_load_bank_o] <= 1'b0;
        end
        if (w_retire) begin
          r_ret_bank          <= ~r_ret_bank;
          r_drain[r_ret_bank] <= DW'(SWAP_CYCLES - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_weight_load_control_unit.sv
// tb_weight_load_control_unit: schedule-based reference model with per-cycle compare,
// directed literal checks for the key timing points, and randomized jobs.
module tb_weight_load_control_unit;
  localparam int M   = 32;
  localparam int SW  = 128;
  localparam int INF = 1 << 30;

  logic        clk, rst, instr, nxt;
  logic [8:0]  w_tiles;
  logic [13:0] base;
  logic        weight_rd_en_o, weight_shift_o, weight_load_bank_o, compute_weights_rdy_o, done_o;
  logic [13:0] weight_rd_addr_o;

  weight_load_control_unit #(.MUL_SIZE(M), .ADDR_W(14), .SWAP_CYCLES(SW)) dut (
    .clk_i(clk), .rst_i(rst), .instruction_i(instr), .W_tiles_i(w_tiles),
    .weight_base_addr_i(base), .next_weight_tile_i(nxt),
    .weight_rd_en_o(weight_rd_en_o), .weight_rd_addr_o(weight_rd_addr_o),
    .weight_shift_o(weight_shift_o), .weight_load_bank_o(weight_load_bank_o),
    .compute_weights_rdy_o(compute_weights_rdy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tiles are scheduled by start cycle; each reads for M cycles,
  // is loaded M+1 cycles after its start, and a retire frees its bank SW cycles later.
  bit          m_job;
  int          m_tiles, m_started, m_s, m_fin, m_full, m_ret;
  int          m_free [2];
  int          m_loaded [$];
  logic [13:0] m_base;
  bit          e_rd, e_shift, e_bank, e_rdy, e_done;
  logic [13:0] e_addr;

  initial begin
    m_job = 0; m_full = 0; m_started = 0; m_s = -INF; m_fin = -1; m_ret = 0;
    m_free[0] = 0; m_free[1] = 0; m_base = '0;
    e_rd = 0; e_shift = 0; e_bank = 1; e_rdy = 0; e_done = 0; e_addr = '0;
  end

  always @(posedge clk) begin
    int n, fp, bk;
    bit sp, rp, jo, fin;
    n = cyc + 1;
    if (rst) begin
      m_job = 0; m_full = 0; m_started = 0; m_s = -INF; m_fin = -1;
      m_loaded.delete();
      e_rd = 0; e_addr = '0; e_shift = 0; e_bank = 1; e_rdy = 0; e_done = 0;
    end else begin
      fp = m_full; sp = e_shift; rp = e_rd; jo = m_job;
      fin = jo && m_fin >= 0 && n - 1 >= m_fin && fp == 0 && !sp;
      e_done = fin;
      if (fin) m_job = 0;
      e_shift = rp;
      if (nxt && fp != 0) begin
        m_full--;
        m_free[(m_ret % 2 == 0) ? 1 : 0] = n - 1 + SW;
        m_ret++;
      end
      while (m_loaded.size() > 0 && m_loaded[0] == n) begin
        void'(m_loaded.pop_front());
        m_full++;
      end
      if (!jo && instr) begin
        m_job = 1; m_tiles = int'(w_tiles); m_base = base; m_started = 0; m_ret = 0;
        m_free[0] = 0; m_free[1] = 0; m_s = -INF; m_loaded.delete();
        m_fin = (w_tiles == 0) ? n : -1;
      end
      bk = (m_started % 2 == 0) ? 1 : 0;
      if (m_job && m_started < m_tiles && n >= m_s + M && n >= m_free[bk] && fp < 2) begin
        m_free[bk] = INF;
        m_s = n;
        m_started++;
        m_loaded.push_back(n + M + 1);
        if (m_started == m_tiles) m_fin = n + M;
      end
      e_rdy  = m_full != 0;
      e_rd   = m_job && n >= m_s && n < m_s + M;
      e_addr = m_base + 14'((m_started - 1) * M + (n - m_s));
      e_bank = ((m_started - int'(e_rd)) % 2) == 0;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("rd_en", 32'(weight_rd_en_o), 32'(e_rd));
      if (e_rd) chk("rd_addr", 32'(weight_rd_addr_o), 32'(e_addr));
      chk("shift", 32'(weight_shift_o), 32'(e_shift));
      chk("load_bank", 32'(weight_load_bank_o), 32'(e_bank));
      chk("rdy", 32'(compute_weights_rdy_o), 32'(e_rdy));
      chk("done", 32'(done_o), 32'(e_done));
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_job(input int w, input logic [13:0] b, output int t);
    t = cyc;
    instr = 1'b1; w_tiles = 9'(w); base = b;
    @(negedge clk);
    instr = 1'b0;
  endtask

  task automatic pulse();
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k;
    rst = 1'b1; instr = 1'b0; nxt = 1'b0; w_tiles = '0; base = '0;
    go_to(2);
    chk("reset_bank", 32'(weight_load_bank_o), 32'd1);
    chk("reset_rd_en", 32'(weight_rd_en_o), 32'd0);
    chk("reset_rdy", 32'(compute_weights_rdy_o), 32'd0);
    go_to(3);
    rst = 1'b0;
    go_to(6);
    pulse();
    pulse();
    go_to(10);
    // single tile
    start_job(1, 14'h100, t);
    go_to(t + 1);  chk("t1_first_addr", 32'(weight_rd_addr_o), 32'h100);
    chk("t1_first_rd", 32'(weight_rd_en_o), 32'd1);
    go_to(t + 2);  chk("t1_first_shift", 32'(weight_shift_o), 32'd1);
    go_to(t + 32); chk("t1_last_addr", 32'(weight_rd_addr_o), 32'h11F);
    go_to(t + 33); chk("t1_rd_off", 32'(weight_rd_en_o), 32'd0);
    chk("t1_rdy_early", 32'(compute_weights_rdy_o), 32'd0);
    go_to(t + 34); chk("t1_rdy_rise", 32'(compute_weights_rdy_o), 32'd1);
    go_to(t + 40); pulse();
    chk("t1_rdy_fall", 32'(compute_weights_rdy_o), 32'd0);
    go_to(t + 42); chk("t1_done", 32'(done_o), 32'd1);
    go_to(t + 45);
    // zero tiles
    start_job(0, 14'h055, t);
    go_to(t + 1); chk("w0_no_done_yet", 32'(done_o), 32'd0);
    chk("w0_no_read", 32'(weight_rd_en_o), 32'd0);
    go_to(t + 2); chk("w0_done", 32'(done_o), 32'd1);
    go_to(t + 5);
    // address wrap
    start_job(1, 14'h3FF0, t);
    go_to(t + 16); chk("wrap_top", 32'(weight_rd_addr_o), 32'h3FFF);
    go_to(t + 17); chk("wrap_zero", 32'(weight_rd_addr_o), 32'h0000);
    go_to(t + 40); pulse();
    go_to(t + 42); chk("wrap_done", 32'(done_o), 32'd1);
    go_to(t + 45);
    // three tiles, late retire
    start_job(3, 14'h0200, t);
    go_to(t + 33); chk("t3_second_back2back", 32'(weight_rd_en_o), 32'd1);
    chk("t3_bank0", 32'(weight_load_bank_o), 32'd0);
    go_to(t + 65); chk("t3_stall", 32'(weight_rd_en_o), 32'd0);
    go_to(t + 100); pulse();
    go_to(t + 227); chk("t3_still_stalled", 32'(weight_rd_en_o), 32'd0);
    chk("t3_rdy_held", 32'(compute_weights_rdy_o), 32'd1);
    go_to(t + 228); chk("t3_third_start", 32'(weight_rd_en_o), 32'd1);
    chk("t3_third_addr", 32'(weight_rd_addr_o), 32'h0240);
    chk("t3_third_bank", 32'(weight_load_bank_o), 32'd1);
    go_to(t + 300); pulse();
    go_to(t + 320); pulse();
    go_to(t + 322); chk("t3_done", 32'(done_o), 32'd1);
    go_to(t + 325);
    // starvation
    start_job(2, 14'h1000, t);
    go_to(t + 40); pulse();
    chk("starve_low", 32'(compute_weights_rdy_o), 32'd0);
    go_to(t + 65); chk("starve_still_low", 32'(compute_weights_rdy_o), 32'd0);
    go_to(t + 66); chk("starve_back", 32'(compute_weights_rdy_o), 32'd1);
    go_to(t + 70); pulse();
    go_to(t + 72); chk("starve_done", 32'(done_o), 32'd1);
    go_to(t + 75);
    // retire coinciding with tile completion
    start_job(2, 14'h2000, t);
    go_to(t + 65); pulse();
    chk("simul_rdy", 32'(compute_weights_rdy_o), 32'd1);
    go_to(t + 70); pulse();
    chk("simul_empty", 32'(compute_weights_rdy_o), 32'd0);
    go_to(t + 72); chk("simul_done", 32'(done_o), 32'd1);
    go_to(t + 75);
    // reset mid-load
    start_job(2, 14'h0123, t);
    go_to(t + 10); rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_en", 32'(weight_rd_en_o), 32'd0);
    chk("rst_shift", 32'(weight_shift_o), 32'd0);
    chk("rst_bank", 32'(weight_load_bank_o), 32'd1);
    rst = 1'b0;
    go_to(t + 60); chk("rst_no_rdy", 32'(compute_weights_rdy_o), 32'd0);
    // randomized jobs
    for (int j = 0; j < 14; j++) begin
      start_job(int'($urandom_range(0, 4)), 14'($urandom), t);
      k = 0;
      while (!done_o && k < 4000) begin
        nxt   = ($urandom_range(0, 15) == 0);
        instr = ($urandom_range(0, 63) == 0);
        w_tiles = 9'($urandom_range(0, 4));
        @(negedge clk);
        k++;
      end
      nxt = 1'b0; instr = 1'b0;
      chk("rand_job_done", 32'(done_o), 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    go_to(cyc + 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
